// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential fetch FSM, instruction-memory handshake and PC/instr FIFO.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to the datapath when the queue is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_active;
    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_req_addr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [63:0]   r_mem_pc    [DEPTH];

    logic          w_wait_ack;
    logic          w_bypass;
    logic          w_byp_take;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic          w_has_room;
    logic          w_unused_bits;

    assign w_wait_ack = (r_state == ST_WAIT) && imem_ack;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_wait_ack && (r_count == '0) && !redirect;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that the datapath accepts never occupies a FIFO slot.
    assign w_byp_take   = w_bypass && instr_ready;
    assign w_pop        = (r_count != '0) && instr_ready && !redirect;
    assign w_push       = w_wait_ack && !redirect && !w_byp_take;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_has_room   = (w_count_next < CW'(DEPTH));

    assign w_unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_active   <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else begin
            if (redirect) begin
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_fetch_pc <= {redirect_pc[63:2], 2'b00};
            end else begin
                if (w_push) begin
                    r_mem_instr[r_wr_ptr] <= imem_rdata;
                    r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
                    r_wr_ptr              <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_next;
                if (w_wait_ack) begin
                    r_fetch_pc <= r_fetch_pc + 64'd4;
                end
            end

            // Remember the address in flight so a drain keeps presenting it.
            if (r_state == ST_WAIT) begin
                r_req_addr <= r_fetch_pc;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!redirect && w_has_room) begin
                        r_state  <= ST_WAIT;
                        r_active <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            r_state  <= ST_IDLE;
                            r_active <= 1'b0;
                        end else begin
                            r_state  <= ST_DRAIN;
                            r_active <= 1'b1;
                        end
                    end else if (imem_ack && !w_has_room) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!redirect && imem_ack) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_active;
    assign busy        = r_active;
    assign imem_addr   = (r_state == ST_DRAIN) ? r_req_addr : r_fetch_pc;
    assign instr_valid = (r_count != '0) || w_bypass;
    assign instr       = w_bypass ? imem_rdata : r_mem_instr[r_rd_ptr];
    assign instr_pc    = w_bypass ? r_fetch_pc : r_mem_pc[r_rd_ptr];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model, scoreboard of fetched words, vector table and corner sequences.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        busy;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [95:0] exp_q[$];
    logic [63:0] exp_pc;
    bit          stale;
    int          mem_wait;
    int          ack_delay;

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    // Called at a falling edge: memory model drives its response, outputs settle.
    task automatic drive();
        imem_ack   = (imem_req && (mem_wait >= ack_delay)) ? 1'b1 : 1'b0;
        imem_rdata = rdata_of(imem_addr);
        #1;
    endtask

    // Update the scoreboard with what the coming rising edge will do, then advance one cycle.
    task automatic commit();
        logic [95:0] e;
        if (imem_req && imem_ack && !stale && !redirect) begin
            check("fetch_addr", imem_addr, exp_pc);
            exp_q.push_back({imem_addr, imem_rdata});
            exp_pc = exp_pc + 64'd4;
        end
        if (instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_empty: got pc %0h expected no instruction", instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", instr_pc, e[95:32]);
                check("pop_instr", {32'b0, instr}, {32'b0, e[31:0]});
            end
        end
        if (redirect) begin
            exp_q.delete();
            exp_pc = {redirect_pc[63:2], 2'b00};
            stale  = imem_req && !imem_ack;
        end else if (imem_req && imem_ack) begin
            stale = 1'b0;
        end
        mem_wait = (imem_req && !imem_ack) ? mem_wait + 1 : 0;
        @(posedge clk);
        @(negedge clk);
        check("count_le_depth", {63'b0, (dut.r_count <= DEPTH)}, 64'd1);
    endtask

    task automatic cycle();
        drive();
        commit();
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_pc   = 64'h0;
        stale    = 1'b0;
        mem_wait = 0;
        reset    = 1'b1;
    endtask

    task automatic run_until_addr(input logic [63:0] a, input int max_cyc);
        int n;
        n = 0;
        while (!(imem_req && imem_addr == a) && n < max_cyc) begin
            cycle();
            n++;
        end
        check("reach_addr", imem_addr, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 1'b0, 64'h00, 1'b0, 64'h0};
`ifdef FETCH_QUEUE_BYPASS_EN
        vt[1] = '{1'b0, 1'b1, 64'h00, 1'b1, 64'h0};
`else
        vt[1] = '{1'b0, 1'b1, 64'h00, 1'b0, 64'h0};
`endif
        vt[2] = '{1'b0, 1'b1, 64'h04, 1'b1, 64'h0};
        vt[3] = '{1'b0, 1'b1, 64'h08, 1'b1, 64'h0};
        vt[4] = '{1'b0, 1'b1, 64'h0C, 1'b1, 64'h0};
        vt[5] = '{1'b0, 1'b0, 64'h10, 1'b1, 64'h0};
        vt[6] = '{1'b0, 1'b0, 64'h10, 1'b1, 64'h0};
        vt[7] = '{1'b1, 1'b0, 64'h10, 1'b1, 64'h0};
        vt[8] = '{1'b1, 1'b1, 64'h10, 1'b1, 64'h4};
        vt[9] = '{1'b1, 1'b1, 64'h14, 1'b1, 64'h8};

        // Reset values
        exp_q.delete();
        exp_pc = 0; stale = 0; mem_wait = 0; ack_delay = 0;
        repeat (2) @(negedge clk);
        check("rst_req", {63'b0, imem_req}, 64'd0);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_valid", {63'b0, instr_valid}, 64'd0);
        check("rst_instr", {32'b0, instr}, 64'd0);
        check("rst_pc", instr_pc, 64'h0);
        check("rst_busy", {63'b0, busy}, 64'd0);

        // Streaming fetch with immediate acks and a consumer that is always ready
        do_reset();
        ack_delay   = 0;
        instr_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive();
            if (i >= 1) check("stream_req", {63'b0, imem_req}, 64'd1);
            if (i >= 2) check("stream_valid", {63'b0, instr_valid}, 64'd1);
            commit();
        end

        // Vector table: fill to DEPTH with consumer stalled, then resume
        do_reset();
        ack_delay = 0;
        for (int i = 0; i < 10; i++) begin
            instr_ready = vt[i].ready;
            drive();
            check($sformatf("vec%0d_req", i), {63'b0, imem_req}, {63'b0, vt[i].exp_req});
            check($sformatf("vec%0d_busy", i), {63'b0, busy}, {63'b0, vt[i].exp_req});
            check($sformatf("vec%0d_addr", i), imem_addr, vt[i].exp_addr);
            check($sformatf("vec%0d_valid", i), {63'b0, instr_valid}, {63'b0, vt[i].exp_valid});
            if (vt[i].exp_valid) check($sformatf("vec%0d_pc", i), instr_pc, vt[i].exp_pc);
            commit();
        end

        // Redirect while a slow request is outstanding: drain the stale fetch
        do_reset();
        ack_delay   = 3;
        instr_ready = 1'b1;
        run_until_addr(64'h8, 40);
        redirect    = 1'b1;
        redirect_pc = 64'h1003;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive();
            check("drain_addr", imem_addr, 64'h8);
            check("drain_req", {63'b0, imem_req}, 64'd1);
            check("drain_busy", {63'b0, busy}, 64'd1);
            check("drain_valid", {63'b0, instr_valid}, 64'd0);
            commit();
        end
        drive();
        check("post_drain_req", {63'b0, imem_req}, 64'd0);
        check("post_drain_addr", imem_addr, 64'h1000);
        check("post_drain_valid", {63'b0, instr_valid}, 64'd0);
        commit();
        drive();
        check("redir_req", {63'b0, imem_req}, 64'd1);
        check("redir_addr", imem_addr, 64'h1000);
        commit();
        repeat (10) cycle();

        // Redirect coinciding with an ack and a pop
        do_reset();
        ack_delay   = 0;
        instr_ready = 1'b1;
        run_until_addr(64'h20, 40);
        check("pre_redir_valid", {63'b0, instr_valid}, 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        cycle();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        drive();
        check("ack_redir_valid", {63'b0, instr_valid}, 64'd0);
        check("ack_redir_count", {61'b0, dut.r_count}, 64'd0);
        check("ack_redir_req", {63'b0, imem_req}, 64'd0);
        check("ack_redir_addr", imem_addr, 64'h2000);
        commit();
        drive();
        check("ack_redir_next_req", {63'b0, imem_req}, 64'd1);
        check("ack_redir_next_addr", imem_addr, 64'h2000);
        commit();
        instr_ready = 1'b1;
        repeat (8) cycle();

        // Asynchronous reset mid-request with three entries queued
        do_reset();
        ack_delay = 0;
        repeat (4) cycle();
        check("pre_rst_count", {61'b0, dut.r_count}, 64'd3);
        check("pre_rst_addr", imem_addr, 64'hC);
        #2;
        reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("async_rst_req", {63'b0, imem_req}, 64'd0);
        check("async_rst_valid", {63'b0, instr_valid}, 64'd0);
        check("async_rst_addr", imem_addr, 64'h0);
        check("async_rst_busy", {63'b0, busy}, 64'd0);
        do_reset();
        cycle();
        drive();
        check("restart_req", {63'b0, imem_req}, 64'd1);
        check("restart_addr", imem_addr, 64'h0);
        commit();
        instr_ready = 1'b1;
        repeat (8) cycle();

`ifdef FETCH_QUEUE_BYPASS_EN
        // Bypass: empty queue, response consumed in the ack cycle
        do_reset();
        ack_delay   = 0;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        cycle();
        redirect = 1'b0;
        cycle();
        drive();
        check("byp_valid", {63'b0, instr_valid}, 64'd1);
        check("byp_pc", instr_pc, 64'h40);
        check("byp_instr", {32'b0, instr}, {32'b0, rdata_of(64'h40)});
        commit();
        check("byp_count", {61'b0, dut.r_count}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the 64-bit datapath.
- Generates sequential fetch addresses, handshakes with the instruction memory, and buffers returned words with their PCs in a small FIFO.
- Supplies instr/instr_pc to the datapath through a valid/ready interface.
- Flushes on branch/jump redirect.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 64'h0, fetch address after reset

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
imem_req  output  1  fetch request to instruction memory
imem_addr  output  64  fetch byte address; bits [1:0] always 0
imem_ack  input  1  memory response valid; meaningful only while imem_req=1
imem_rdata  input  32  instruction word, valid with imem_ack
instr_valid  output  1  queue head holds a valid instruction
instr  output  32  instruction at queue head
instr_pc  output  64  PC of instr
instr_ready  input  1  datapath consumes head this cycle
redirect  input  1  taken branch/jump: flush and restart fetch
redirect_pc  input  64  new fetch address; bits [1:0] ignored (treated as 0)
busy  output  1  request outstanding (state WAIT or DRAIN)

Behaviour:
- Reset (reset=0, async): state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers=0, all FIFO storage=0. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, busy=0.
- FSM states:
  - IDLE: imem_req=0. Go to WAIT if no redirect and count_next < DEPTH, where count_next counts this cycle's pop.
  - WAIT: imem_req=1, imem_addr=fetch_pc, held stable until ack. No abort; memory may take any number of cycles.
  - DRAIN: imem_req=1 at the stale address until ack. Response discarded.
- WAIT + ack, no redirect:
  - Push {fetch_pc, imem_rdata} at wr_ptr; fetch_pc += 4 (64-bit wrap).
  - Stay in WAIT (back-to-back requests) if count after push and pop < DEPTH, else go to IDLE.
- Redirect:
  - Priority over push and pop in the same cycle.
  - count, rd_ptr, wr_ptr cleared; fetch_pc <= {redirect_pc[63:2], 2'b00}.
  - From WAIT without ack -> DRAIN.
  - From WAIT with ack -> IDLE; data discarded, fetch_pc not incremented.
  - From DRAIN -> stays in DRAIN; fetch_pc updated again.
  - From IDLE -> IDLE.
- DRAIN + ack, no redirect -> IDLE; data dropped; fetch_pc unchanged (already holds the redirect target).
- While in DRAIN, imem_addr = address captured when the stale request was issued (held in a separate req_addr register).
- Pop: instr_valid && instr_ready && !redirect -> rd_ptr++ and count--. instr_ready while instr_valid=0 is ignored.
- Simultaneous push and pop -> count unchanged.
- Overflow impossible: a request issues only when space is guaranteed. Bench asserts count <= DEPTH.
- instr_valid = (count != 0); instr/instr_pc driven from storage at rd_ptr.
- Pointer widths: log2(DEPTH); pointers wrap naturally.
- Latency: redirect at edge N -> imem_req for the new PC asserted after edge N+1 (IDLE -> WAIT), unless draining.

Optional Feature:
FETCH_QUEUE_BYPASS_EN:
- Defined: when count=0 and state=WAIT with imem_ack=1, instr_valid=1 combinationally, with instr=imem_rdata and instr_pc=fetch_pc in the same cycle.
  - If instr_ready=1 the word is consumed without a push.
  - If redirect is asserted, bypass is suppressed.
- Not defined: every response is pushed first; earliest instr_valid is one cycle after ack.

Test Plan:
1. Release reset, memory acks every cycle with rdata = addr[31:0]^32'hA5A5_0000, instr_ready=1 -> imem_addr sequence 0,4,8,...; instr_pc 0,4,8 in order with matching instr; no gaps after the first fill.
2. instr_ready=0, DEPTH=4, immediate acks -> exactly 4 pushes (PCs 0..C); then imem_req=0 and state IDLE. Raise instr_ready -> fetch resumes at 0x10.
3. Redirect to 0x1003 while WAIT at 0x8 and ack delayed 3 cycles -> imem_addr stays 0x8 until ack; that word is dropped; next request is 0x1000; queue empty in between.
4. Redirect to 0x2000 in the same cycle as ack for 0x20 and a pop -> nothing pushed; head not advanced; count=0; next imem_addr=0x2000.
5. Assert reset low mid-WAIT with 3 entries queued -> imem_req=0, instr_valid=0, imem_addr=RESET_PC immediately (async); fetch restarts at RESET_PC after release.
6. FETCH_QUEUE_BYPASS_EN defined, empty queue, ack for 0x40 with instr_ready=1 -> instr_valid=1 and instr_pc=0x40 in the ack cycle; count stays 0.
